// File: rtl/pong_game_engine.sv
// Pong game-state engine: advances ball, scores and game phase once per frame
// on the rising edge of vsync, feeding positions to the video encoder.
module pong_game_engine #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int BALL_SIZE   = 16,
  parameter int PADDLE_W    = 16,
  parameter int PADDLE_H    = 128,
  parameter int P1_X        = 32,
  parameter int P2_X        = 1232,
  parameter int SPEED       = 4,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic [1:0]  mode,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [5:0]  p1_score,
  output logic [5:0]  p2_score,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [11:0] BALL      = 12'(BALL_SIZE);
  localparam logic [11:0] STEP      = 12'(SPEED);
  localparam logic [11:0] PAD_H     = 12'(PADDLE_H);
  localparam logic [11:0] X_MAX     = 12'(H_ACTIVE - BALL_SIZE);
  localparam logic [11:0] Y_MAX     = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic [11:0] X_CTR     = 12'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] Y_CTR     = 12'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] P1_EDGE   = 12'(P1_X + PADDLE_W);
  localparam logic [11:0] P2_EDGE   = 12'(P2_X);
  localparam logic [11:0] P2_STOP   = 12'(P2_X - BALL_SIZE);
  localparam logic [7:0]  SERVE_CNT = 8'(SERVE_DELAY);
  localparam logic [5:0]  WIN       = 6'(WIN_SCORE);

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_PLAY = 2'b01;
  localparam logic [1:0] MODE_NEW  = 2'b11;

  typedef enum logic [1:0] {
    ST_SERVE = 2'b00,
    ST_MOVE  = 2'b01,
    ST_POINT = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  state_t      state_r;
  logic        vsync_q_r;
  logic [7:0]  cnt_r;
  logic [11:0] x_r;
  logic [11:0] y_r;
  logic        dx_left_r;
  logic        dy_up_r;
  logic [5:0]  s1_r;
  logic [5:0]  s2_r;
  logic        scorer_p1_r;
  logic        game_over_r;
  logic [1:0]  winner_r;

  logic        tick_s;
  logic        clear_s;
  logic        ov1_s;
  logic        ov2_s;
  logic [11:0] nx_s;
  logic [11:0] ny_s;
  logic        ndx_left_s;
  logic        ndy_up_s;
  logic        miss_s;
  logic        miss_p1_s;
  logic [5:0]  s1_inc_s;
  logic [5:0]  s2_inc_s;
  logic [7:0]  cnt_inc_s;

  assign tick_s    = vsync & ~vsync_q_r;
  assign clear_s   = rst | (mode == MODE_NEW);
  assign cnt_inc_s = cnt_r + 8'd1;
  assign s1_inc_s  = (s1_r == 6'd63) ? 6'd63 : s1_r + 6'd1;
  assign s2_inc_s  = (s2_r == 6'd63) ? 6'd63 : s2_r + 6'd1;

  // Paddle overlap is judged on the pre-move ball_y; paddle inputs are widened, never clamped
  assign ov1_s = ((y_r + BALL) > {1'b0, p1_y}) && (y_r < ({1'b0, p1_y} + PAD_H));
  assign ov2_s = ((y_r + BALL) > {1'b0, p2_y}) && (y_r < ({1'b0, p2_y} + PAD_H));

  // Next ball position for a MOVE tick; both axes resolve independently
  always_comb begin
    nx_s       = x_r;
    ny_s       = y_r;
    ndx_left_s = dx_left_r;
    ndy_up_s   = dy_up_r;
    miss_s     = 1'b0;
    miss_p1_s  = 1'b0;

    if (dy_up_r) begin
      if (y_r < STEP) begin
        ny_s     = 12'd0;
        ndy_up_s = 1'b0;
      end else begin
        ny_s = y_r - STEP;
      end
    end else begin
      if ((y_r + STEP) > Y_MAX) begin
        ny_s     = Y_MAX;
        ndy_up_s = 1'b1;
      end else begin
        ny_s = y_r + STEP;
      end
    end

    // x - SPEED <= edge is rewritten as x <= edge + SPEED to avoid underflow
    if (dx_left_r) begin
      if ((x_r >= P1_EDGE) && (x_r <= (P1_EDGE + STEP)) && ov1_s) begin
        nx_s       = P1_EDGE;
        ndx_left_s = 1'b0;
      end else if (x_r < STEP) begin
        nx_s      = 12'd0;
        miss_s    = 1'b1;
        miss_p1_s = 1'b0;
      end else begin
        nx_s = x_r - STEP;
      end
    end else begin
      if (((x_r + BALL) <= P2_EDGE) && ((x_r + STEP + BALL) >= P2_EDGE) && ov2_s) begin
        nx_s       = P2_STOP;
        ndx_left_s = 1'b1;
      end else if ((x_r + STEP) > X_MAX) begin
        nx_s      = X_MAX;
        miss_s    = 1'b1;
        miss_p1_s = 1'b1;
      end else begin
        nx_s = x_r + STEP;
      end
    end
  end

  // Frame-edge detector: follows vsync even during a new-game request
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q_r <= 1'b0;
    end else begin
      vsync_q_r <= vsync;
    end
  end

  // Game FSM with mode overrides; every output is driven straight from these registers
  always_ff @(posedge clk) begin
    if (clear_s) begin
      state_r     <= ST_SERVE;
      cnt_r       <= 8'd0;
      x_r         <= X_CTR;
      y_r         <= Y_CTR;
      dx_left_r   <= 1'b0;
      dy_up_r     <= 1'b0;
      s1_r        <= 6'd0;
      s2_r        <= 6'd0;
      scorer_p1_r <= 1'b0;
      game_over_r <= 1'b0;
      winner_r    <= 2'b00;
    end else begin
      case (mode)
        MODE_IDLE: begin
          x_r         <= X_CTR;
          y_r         <= Y_CTR;
          state_r     <= ST_SERVE;
          cnt_r       <= 8'd0;
          game_over_r <= 1'b0;
        end
        MODE_PLAY: begin
          if (tick_s) begin
            case (state_r)
              ST_SERVE: begin
                x_r <= X_CTR;
                y_r <= Y_CTR;
                if (cnt_inc_s == SERVE_CNT) begin
                  cnt_r   <= 8'd0;
                  state_r <= ST_MOVE;
                end else begin
                  cnt_r <= cnt_inc_s;
                end
              end
              ST_MOVE: begin
                x_r       <= nx_s;
                y_r       <= ny_s;
                dx_left_r <= ndx_left_s;
                dy_up_r   <= ndy_up_s;
                if (miss_s) begin
                  state_r     <= ST_POINT;
                  scorer_p1_r <= miss_p1_s;
                end
              end
              ST_POINT: begin
                x_r     <= X_CTR;
                y_r     <= Y_CTR;
                dy_up_r <= 1'b0;
                cnt_r   <= 8'd0;
                if (scorer_p1_r) begin
                  s1_r <= s1_inc_s;
                  if (s1_inc_s >= WIN) begin
                    state_r     <= ST_OVER;
                    game_over_r <= 1'b1;
                    winner_r    <= 2'b01;
                  end else begin
                    state_r   <= ST_SERVE;
                    dx_left_r <= 1'b1;
                  end
                end else begin
                  s2_r <= s2_inc_s;
                  if (s2_inc_s >= WIN) begin
                    state_r     <= ST_OVER;
                    game_over_r <= 1'b1;
                    winner_r    <= 2'b10;
                  end else begin
                    state_r   <= ST_SERVE;
                    dx_left_r <= 1'b0;
                  end
                end
              end
              ST_OVER: begin
                x_r         <= X_CTR;
                y_r         <= Y_CTR;
                game_over_r <= 1'b1;
              end
              default: begin
                state_r <= ST_SERVE;
              end
            endcase
          end
        end
        default: begin
          // pause holds everything
        end
      endcase
    end
  end

  assign ball_x    = x_r[10:0];
  assign ball_y    = y_r[10:0];
  assign p1_score  = s1_r;
  assign p2_score  = s2_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;

endmodule

// File: tb/tb_pong_game_engine.sv
// Scoreboard bench for pong_game_engine: each vsync pulse queues its expected
// outcome and an independent monitor checks the DUT after the frame tick.
module tb_pong_game_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [1:0]  mode;
  logic [10:0] p1_man;
  logic [10:0] p2_y;
  logic        track;
  logic [10:0] p1_y;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [5:0]  p1_score;
  logic [5:0]  p2_score;
  logic        game_over;
  logic [1:0]  winner;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          cp;
    bit          cs;
    logic [10:0] x;
    logic [10:0] y;
    logic [5:0]  s1;
    logic [5:0]  s2;
    logic        go;
    logic [1:0]  w;
  } exp_t;

  exp_t sb[$];

  // P1 "player" can follow the ball so its rallies always return
  assign p1_y = track ? ball_y : p1_man;

  pong_game_engine #(.SERVE_DELAY(2), .SPEED(4)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .mode(mode),
    .p1_y(p1_y), .p2_y(p2_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .p1_score(p1_score), .p2_score(p2_score),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int x, input int y,
                           input int s1, input int s2, input int go, input int w);
    cmp({tag, ".ball_x"}, int'(ball_x), x);
    cmp({tag, ".ball_y"}, int'(ball_y), y);
    cmp({tag, ".p1_score"}, int'(p1_score), s1);
    cmp({tag, ".p2_score"}, int'(p2_score), s2);
    cmp({tag, ".game_over"}, int'(game_over), go);
    cmp({tag, ".winner"}, int'(winner), w);
  endtask

  task automatic pulse(input exp_t e);
    sb.push_back(e);
    @(negedge clk) vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic tick_none(input int n);
    exp_t e;
    e = '{cp: 1'b0, cs: 1'b0, x: 11'd0, y: 11'd0, s1: 6'd0, s2: 6'd0, go: 1'b0, w: 2'd0};
    for (int i = 0; i < n; i++) pulse(e);
  endtask

  task automatic tick_pos(input int x, input int y);
    exp_t e;
    e = '{cp: 1'b1, cs: 1'b0, x: 11'(x), y: 11'(y), s1: 6'd0, s2: 6'd0, go: 1'b0, w: 2'd0};
    pulse(e);
  endtask

  task automatic tick_full(input int x, input int y, input int s1, input int s2,
                           input int go, input int w);
    exp_t e;
    e = '{cp: 1'b1, cs: 1'b1, x: 11'(x), y: 11'(y), s1: 6'(s1), s2: 6'(s2),
          go: 1'(go), w: 2'(w)};
    pulse(e);
  endtask

  // Monitor: after each frame tick has taken effect, pop and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge vsync);
      repeat (2) @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_underflow: got tick with no expectation queued");
      end else begin
        e = sb.pop_front();
        if (e.cp) begin
          cmp("tick.ball_x", int'(ball_x), int'(e.x));
          cmp("tick.ball_y", int'(ball_y), int'(e.y));
        end
        if (e.cs) begin
          cmp("tick.p1_score", int'(p1_score), int'(e.s1));
          cmp("tick.p2_score", int'(p2_score), int'(e.s2));
          cmp("tick.game_over", int'(game_over), int'(e.go));
          cmp("tick.winner", int'(winner), int'(e.w));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vsync = 1'b0; mode = 2'b01;
    p1_man = 11'd0; p2_y = 11'd400; track = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("reset", 632, 352, 0, 0, 0, 0);

    // Serve delay then first move
    tick_pos(632, 352);
    tick_pos(632, 352);
    tick_pos(636, 356);
    // Bottom wall: reach 704, clamp and flip, then climb
    tick_none(86);
    tick_pos(984, 704);
    tick_pos(988, 704);
    tick_pos(992, 700);
    // P2 paddle hit at p2_y=400
    tick_none(55);
    tick_pos(1216, 476);
    tick_pos(1212, 472);
    // Top wall
    tick_none(117);
    tick_pos(740, 0);
    tick_pos(736, 0);
    tick_pos(732, 4);
    // P1 misses (paddle at 0), P2 scores
    tick_none(183);
    tick_pos(0, 672);
    tick_full(632, 352, 0, 1, 0, 0);

    // P1 tracks the ball, P2 paddle out of reach: P1 wins every rally
    track = 1'b1; p2_y = 11'd2000;
    tick_none(161);
    tick_full(632, 352, 1, 1, 0, 0);
    tick_pos(632, 352);
    tick_pos(632, 352);
    tick_pos(628, 356);
    tick_none(450);
    tick_full(632, 352, 2, 1, 0, 0);
    for (int s = 3; s <= 11; s++) begin
      tick_none(453);
      tick_full(632, 352, s, 1, (s == 11) ? 1 : 0, (s == 11) ? 1 : 0);
    end
    // OVER holds
    for (int i = 0; i < 3; i++) tick_full(632, 352, 11, 1, 1, 1);

    // New game request for one clock
    @(negedge clk) mode = 2'b11;
    @(negedge clk) mode = 2'b01;
    check_all("new_game", 632, 352, 0, 0, 0, 0);

    // Pause freezes the ball
    tick_pos(632, 352);
    tick_pos(632, 352);
    tick_pos(636, 356);
    mode = 2'b10;
    for (int i = 0; i < 5; i++) tick_pos(636, 356);
    mode = 2'b01;
    tick_pos(640, 360);
    // Idle recentres on the next clock
    @(negedge clk) mode = 2'b00;
    @(negedge clk);
    cmp("idle.ball_x", int'(ball_x), 632);
    cmp("idle.ball_y", int'(ball_y), 352);
    mode = 2'b01;

    // Drive to POINT (P2 miss), then reset in the middle of it
    tick_none(160);
    tick_pos(1264, 424);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_all("rst_point", 632, 352, 0, 0, 0, 0);
    tick_pos(632, 352);
    tick_pos(632, 352);
    tick_full(636, 356, 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
